uart_cmd_parser: RTL and testbench

Downstream consumer of the UART receiver's byte stream (byte_data/data_valid).
- Frames received bytes into fixed 6-byte command packets and checks an XOR checksum.
- Valid packets become either a single-cycle write strobe into the VGA pixel/tile memory, or an update of the display-mode register.
- Malformed, unknown or stalled packets are discarded and counted.

---
 rtl/uart_cmd_parser.sv | 106 ++++++++++
 tb/tb_uart_cmd_parser.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames UART bytes into 6-byte command packets and drives pixel writes or mode updates
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [19:0] TIMEOUT   = 20'd1000000,
    parameter int          ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        byte_data,
    input  logic              data_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        mode,
    output logic              frame_err,
    output logic [7:0]        err_cnt,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, CMD, AHI, ALO, DATA, CHK} state_t;
    state_t state, next;
    logic prev_valid;
    logic [7:0] cmd, ahi, alo, dat, xacc;
    logic [19:0] cnt;
    logic acc, tmo, do_wr, do_mode, do_err;

    assign acc  = data_valid & ~prev_valid;
    assign tmo  = (state != IDLE) && !acc && (cnt == TIMEOUT - 20'd1);
    assign busy = state != IDLE;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;

    // next state and frame verdict; an arriving byte overrides a timeout
    always_comb begin
        next    = state;
        do_wr   = 1'b0;
        do_mode = 1'b0;
        do_err  = 1'b0;
        if (tmo) begin
            next   = IDLE;
            do_err = 1'b1;
        end else if (acc) begin
            case (state)
                IDLE: if (byte_data == SYNC_BYTE) next = CMD;
                CMD:  next = AHI;
                AHI:  next = ALO;
                ALO:  next = DATA;
                DATA: next = CHK;
                CHK: begin
                    next = IDLE;
                    if (byte_data != xacc) do_err = 1'b1;
                    else if (cmd == 8'h01) do_wr = 1'b1;
                    else if (cmd == 8'h02) do_mode = 1'b1;
                    else do_err = 1'b1;
                end
                default: next = IDLE;
            endcase
        end
    end

    // edge detect, inter-byte timer and payload capture with running checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            cnt        <= '0;
            xacc       <= '0;
            cmd        <= '0;
            ahi        <= '0;
            alo        <= '0;
            dat        <= '0;
        end else begin
            prev_valid <= data_valid;
            cnt        <= (acc || tmo || state == IDLE) ? '0 : cnt + 20'd1;
            if (acc) begin
                xacc <= (state == IDLE) ? 8'h00 : xacc ^ byte_data;
                if (state == CMD)  cmd <= byte_data;
                if (state == AHI)  ahi <= byte_data;
                if (state == ALO)  alo <= byte_data;
                if (state == DATA) dat <= byte_data;
            end
        end
    end

    // registered outputs; address/data hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            mode      <= '0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            wr_en     <= do_wr;
            frame_err <= do_err;
            if (do_wr) begin
                wr_addr <= ADDR_W'({ahi, alo});
                wr_data <= dat;
            end
            if (do_mode) mode <= dat;
            if (do_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: randomized scoreboard bench for uart_cmd_parser
module tb_uart_cmd_parser;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        data_valid = 1'b0;
    logic        wr_en, frame_err, busy;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data, mode, err_cnt;

    uart_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT(20'd50), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .byte_data(byte_data), .data_valid(data_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mode(mode),
        .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pend[$];
    int         m_err = 0;
    logic [7:0] m_mode = 8'h00;
    logic [7:0] prev_mode = 8'h00;
    int         tests = 0;
    int         fails = 0;

    function automatic void err_ev();
        if (m_err < 255) m_err++;
        exp_q.push_back('{3, 16'h0000, 8'(m_err)});
    endfunction

    // reference: a frame is the SYNC byte plus the next five bytes, judged as a whole
    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] x;
        if (pend.size() == 0 && b != 8'hA5) return;
        pend.push_back(b);
        if (pend.size() < 6) return;
        x = pend[1] ^ pend[2] ^ pend[3] ^ pend[4];
        if (x != pend[5] || !(pend[1] == 8'h01 || pend[1] == 8'h02)) err_ev();
        else if (pend[1] == 8'h01) exp_q.push_back('{1, {pend[2], pend[3]}, pend[4]});
        else if (pend[4] != m_mode) begin
            m_mode = pend[4];
            exp_q.push_back('{2, 16'h0000, pend[4]});
        end
        pend.delete();
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: each visible DUT event must match the head of the expected queue
    task automatic observe(input int kind, input logic [15:0] addr, input logic [7:0] data);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected event kind=%0d addr=%h data=%h, expected none", kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr != addr || e.data != data) begin
                fails++;
                $display("FAIL event: got kind=%0d addr=%h data=%h expected kind=%0d addr=%h data=%h",
                         kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) observe(1, wr_addr, wr_data);
            if (frame_err) observe(3, 16'h0000, err_cnt);
            if (mode != prev_mode) observe(2, 16'h0000, mode);
        end
        prev_mode = mode;
    end

    task automatic send(input logic [7:0] b, input int hold, input int gap);
        model_byte(b);
        byte_data  = b;
        data_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1 data_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [15:0] a, input logic [7:0] d,
                              input logic [7:0] chk_flip, input int hold, input int gap);
        send(8'hA5, hold, gap);
        send(c, hold, gap);
        send(a[15:8], hold, gap);
        send(a[7:0], hold, gap);
        send(d, hold, gap);
        send(c ^ a[15:8] ^ a[7:0] ^ d ^ chk_flip, hold, gap);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1 check("drain", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] c, f, nb;
        #12;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_mode", mode, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_busy", busy, 0);
        @(posedge clk) #1 rst_n = 1'b1;
        @(posedge clk) #1;

        send_frame(8'h01, 16'h1234, 8'h5C, 8'h00, 1, 1);
        drain();
        check("pix_addr", wr_addr, 16'h1234);
        check("pix_err_cnt", err_cnt, 0);
        send_frame(8'h02, 16'h0000, 8'h07, 8'h00, 1, 1);
        drain();
        check("mode_set", mode, 8'h07);
        send_frame(8'h01, 16'h1234, 8'h5C, 8'h6B, 1, 1);
        send_frame(8'h09, 16'h0000, 8'h00, 8'h00, 1, 1);
        drain();
        check("err_cnt_2", err_cnt, 2);
        check("hold_addr", wr_addr, 16'h1234);
        send_frame(8'h01, 16'h4321, 8'hC5, 8'h00, 5, 2);
        drain();

        send(8'hA5, 1, 1);
        send(8'h01, 1, 0);
        repeat (49) @(posedge clk);
        #1 check("tmo_busy_before", busy, 1);
        @(posedge clk) #1 check("tmo_busy_after", busy, 0);
        pend.delete();
        err_ev();
        repeat (10) @(posedge clk);
        #1;
        drain();
        send_frame(8'h01, 16'h1234, 8'h5C, 8'h00, 1, 1);
        drain();

        send(8'hA5, 1, 1);
        send(8'h01, 1, 1);
        send(8'h12, 1, 1);
        rst_n = 1'b0;
        pend.delete();
        m_err = 0;
        m_mode = 8'h00;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_wr_en", wr_en, 0);
        check("rstmid_mode", mode, 0);
        check("rstmid_err_cnt", err_cnt, 0);
        @(posedge clk) #1 rst_n = 1'b1;
        @(posedge clk) #1;
        send_frame(8'h01, 16'hBEEF, 8'h3C, 8'h00, 1, 1);
        drain();

        for (int i = 0; i < 200; i++) begin
            int k, h, g;
            k = $urandom_range(0, 4);
            h = $urandom_range(1, 4);
            g = $urandom_range(1, 6);
            c = 8'($urandom);
            if (c == 8'h01 || c == 8'h02) c = 8'h09;
            f = 8'($urandom_range(1, 255));
            nb = 8'($urandom);
            if (nb == 8'hA5) nb = 8'h00;
            case (k)
                0: send_frame(8'h01, 16'($urandom), 8'($urandom), 8'h00, h, g);
                1: send_frame(8'h02, 16'($urandom), 8'($urandom), 8'h00, h, g);
                2: send_frame(8'h01, 16'($urandom), 8'($urandom), f, h, g);
                3: send_frame(c, 16'($urandom), 8'($urandom), 8'h00, h, g);
                default: begin
                    send(nb, h, g);
                    send_frame(8'h01, {8'hA5, 8'($urandom)}, 8'hA5, 8'h00, h, g);
                end
            endcase
        end
        drain();

        for (int i = 0; i < 300; i++) send_frame(8'h01, 16'($urandom), 8'($urandom), 8'h01, 1, 1);
        drain();
        check("err_cnt_sat", err_cnt, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
